// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write controller:
// FSM state encoding, default sizing and the register-index type.
package rf_pkg;

  localparam int RF_NUM_REGS_DEF   = 32;
  localparam int RF_DATA_W_DEF     = 32;
  localparam int RF_STARVE_MAX_DEF = 4;

  typedef enum logic [0:0] {
    RF_RUN  = 1'b0,
    RF_INIT = 1'b1
  } rf_state_e;

  typedef logic [$clog2(RF_NUM_REGS_DEF)-1:0] rf_reg_idx_t;

  // Width of a register index for a register file of num_regs entries.
  function automatic int rf_idx_w(input int num_regs);
    return $clog2(num_regs);
  endfunction

endpackage

// File: rtl/rf_write_controller_if.sv
// Bus bundle between the requesters (writeback, debug, init control)
// and the register-file write controller.
interface rf_write_controller_if
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS_DEF,
  parameter int DATA_W   = RF_DATA_W_DEF
);
  localparam int REG_W = rf_idx_w(NUM_REGS);

  logic              start_init;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              dbg_valid;
  logic              dbg_ready;
  logic [REG_W-1:0]  dbg_reg;
  logic [DATA_W-1:0] dbg_data;
  logic [REG_W-1:0]  rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_reg_write;
  logic              busy;
  logic              init_done;

  // Requester side: issues writes and init requests, observes the write port.
  modport master (
    output start_init, wb_valid, wb_reg, wb_data, dbg_valid, dbg_reg, dbg_data,
    input  wb_ready, dbg_ready, rf_write_reg, rf_write_data, rf_reg_write,
           busy, init_done
  );

  // Controller side.
  modport slave (
    input  start_init, wb_valid, wb_reg, wb_data, dbg_valid, dbg_reg, dbg_data,
    output wb_ready, dbg_ready, rf_write_reg, rf_write_data, rf_reg_write,
           busy, init_done
  );

endinterface

// File: rtl/rf_write_arb.sv
// Two-way write arbiter: writeback has fixed priority, but a debug
// requester that has lost STARVE_MAX times in a row wins the next cycle.
module rf_write_arb
  import rf_pkg::*;
#(
  parameter int STARVE_MAX = RF_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic wb_valid,
  input  logic dbg_valid,
  output logic wb_grant,
  output logic dbg_grant
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic             dbg_forced;

  // Combinational grant; a lone requester is always served immediately.
  always_comb begin
    wb_grant   = 1'b0;
    dbg_grant  = 1'b0;
    dbg_forced = (starve_cnt_reg == CNT_MAX);
    if (en) begin
      if (dbg_valid && (dbg_forced || !wb_valid)) begin
        dbg_grant = 1'b1;
      end else if (wb_valid) begin
        wb_grant = 1'b1;
      end
    end
  end

  // Count consecutive debug losses to writeback, saturating at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (!dbg_valid || dbg_grant) begin
      starve_cnt_reg <= '0;
    end else if (wb_grant && (starve_cnt_reg != CNT_MAX)) begin
      starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rf_write_controller.sv
// Register-file write controller: arbitrates writeback and debug writes
// onto one registered write port and optionally runs a clear sequence
// that zeroes registers 1..NUM_REGS-1.
// Build option: define RF_INIT_CLEAR_EN to include the INIT clear sequence;
// without it start_init is ignored and init_done reads 1 after reset.
module rf_write_controller
  import rf_pkg::*;
#(
  parameter int NUM_REGS   = RF_NUM_REGS_DEF,
  parameter int DATA_W     = RF_DATA_W_DEF,
  parameter int STARVE_MAX = RF_STARVE_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rf_write_controller_if.slave bus
);

  localparam int REG_W = rf_idx_w(NUM_REGS);

  logic              arb_en;
  logic              wb_grant;
  logic              dbg_grant;
  logic              xfer_take;
  logic [REG_W-1:0]  xfer_reg;
  logic [DATA_W-1:0] xfer_data;

  logic [REG_W-1:0]  wr_reg_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              wr_en_reg;
  logic              init_done_reg;

  rf_write_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (arb_en),
    .wb_valid  (bus.wb_valid),
    .dbg_valid (bus.dbg_valid),
    .wb_grant  (wb_grant),
    .dbg_grant (dbg_grant)
  );

  // Select the winning requester's destination and data.
  always_comb begin
    xfer_take = wb_grant | dbg_grant;
    xfer_reg  = bus.wb_reg;
    xfer_data = bus.wb_data;
    if (dbg_grant) begin
      xfer_reg  = bus.dbg_reg;
      xfer_data = bus.dbg_data;
    end
  end

`ifdef RF_INIT_CLEAR_EN
  localparam logic [0:0]       ST_RUN   = 1'(RF_RUN);
  localparam logic [0:0]       ST_INIT  = 1'(RF_INIT);
  localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);

  logic [0:0]       state_reg;
  logic [REG_W-1:0] init_cnt_reg;

  // A start request in RUN pre-empts any grant in the same cycle.
  assign arb_en = (state_reg == ST_RUN) && !bus.start_init;

  // FSM, clear counter and write-port registers. The first clear write
  // (register 1) is issued on entry so writes coincide with busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      init_cnt_reg  <= '0;
      init_done_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_reg_reg    <= '0;
      wr_data_reg   <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.start_init) begin
            state_reg     <= ST_INIT;
            init_done_reg <= 1'b0;
            init_cnt_reg  <= REG_W'(1);
            wr_en_reg     <= 1'b1;
            wr_reg_reg    <= REG_W'(1);
            wr_data_reg   <= '0;
          end else if (xfer_take) begin
            wr_en_reg   <= (xfer_reg != '0);
            wr_reg_reg  <= xfer_reg;
            wr_data_reg <= xfer_data;
          end else begin
            wr_en_reg <= 1'b0;
          end
        end
        default: begin
          if (init_cnt_reg == LAST_REG) begin
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
            init_cnt_reg  <= '0;
            wr_en_reg     <= 1'b0;
          end else begin
            init_cnt_reg <= init_cnt_reg + REG_W'(1);
            wr_en_reg    <= 1'b1;
            wr_reg_reg   <= init_cnt_reg + REG_W'(1);
            wr_data_reg  <= '0;
          end
        end
      endcase
    end
  end

  assign bus.busy = (state_reg == ST_INIT);
`else
  assign arb_en = 1'b1;

  // Write-port registers; with no clear sequence the file counts as
  // initialised from the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      wr_reg_reg    <= '0;
      wr_data_reg   <= '0;
    end else begin
      init_done_reg <= 1'b1;
      if (xfer_take) begin
        wr_en_reg   <= (xfer_reg != '0);
        wr_reg_reg  <= xfer_reg;
        wr_data_reg <= xfer_data;
      end else begin
        wr_en_reg <= 1'b0;
      end
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.wb_ready      = wb_grant;
  assign bus.dbg_ready     = dbg_grant;
  assign bus.rf_reg_write  = wr_en_reg;
  assign bus.rf_write_reg  = wr_reg_reg;
  assign bus.rf_write_data = wr_data_reg;
  assign bus.init_done     = init_done_reg;

endmodule

// File: tb/tb_rf_write_controller.sv
// Directed bench for rf_write_controller with a queue-based reference
// model checked every cycle plus hand-computed spot expectations.
module tb_rf_write_controller;

  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int REG_W      = $clog2(NUM_REGS);
`ifdef RF_INIT_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   cmp_en = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  rf_write_controller_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) bus ();

  rf_write_controller #(
    .NUM_REGS   (NUM_REGS),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  int          m_losses = 0;
  bit          m_in_init = 1'b0;
  int          m_q[$];
  bit          m_done = 1'b0;
  bit          m_we = 1'b0;
  int          m_reg = 0;
  logic [31:0] m_data = '0;

  function automatic void m_grants(output bit gw, output bit gd);
    bit can;
    gw = 1'b0;
    gd = 1'b0;
    can = CLR_EN ? (!m_in_init && !bus.start_init) : 1'b1;
    if (can && bus.dbg_valid && (m_losses >= STARVE_MAX || !bus.wb_valid)) gd = 1'b1;
    else if (can && bus.wb_valid) gw = 1'b1;
  endfunction

  initial begin
    forever begin : mdl
      bit gw, gd, handled;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_losses = 0; m_in_init = 0; m_q.delete(); m_done = 0;
        m_we = 0; m_reg = 0; m_data = '0;
      end else begin
        m_grants(gw, gd);
        handled = 1'b0;
        if (CLR_EN) begin
          if (m_in_init) begin
            handled = 1'b1;
            if (m_q.size() == 0) begin
              m_in_init = 0; m_done = 1; m_we = 0;
            end else begin
              m_reg = m_q.pop_front(); m_data = '0; m_we = 1;
            end
          end else if (bus.start_init) begin
            handled = 1'b1;
            for (int r = 1; r < NUM_REGS; r++) m_q.push_back(r);
            m_in_init = 1; m_done = 0;
            m_reg = m_q.pop_front(); m_data = '0; m_we = 1;
          end
        end else begin
          m_done = 1;
        end
        if (!handled) begin
          if (gw) begin
            m_reg = int'(bus.wb_reg); m_data = bus.wb_data; m_we = (m_reg != 0);
          end else if (gd) begin
            m_reg = int'(bus.dbg_reg); m_data = bus.dbg_data; m_we = (m_reg != 0);
          end else begin
            m_we = 0;
          end
        end
        if (!bus.dbg_valid || gd) m_losses = 0;
        else if (gw && m_losses < STARVE_MAX) m_losses++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin : cmp
      bit gw, gd;
      @(negedge clk);
      if (cmp_en) begin
        m_grants(gw, gd);
        chk("model wb_ready", 64'(bus.wb_ready), 64'(gw));
        chk("model dbg_ready", 64'(bus.dbg_ready), 64'(gd));
        chk("model rf_reg_write", 64'(bus.rf_reg_write), 64'(m_we));
        chk("model rf_write_reg", 64'(bus.rf_write_reg), 64'(m_reg));
        chk("model rf_write_data", 64'(bus.rf_write_data), 64'(m_data));
        chk("model busy", 64'(bus.busy), 64'(m_in_init));
        chk("model init_done", 64'(bus.init_done), 64'(m_done));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit si, input bit wv, input int wr, input logic [31:0] wd,
                        input bit dv, input int dr, input logic [31:0] dd);
    bus.start_init = si;
    bus.wb_valid   = wv;
    bus.wb_reg     = REG_W'(wr);
    bus.wb_data    = wd;
    bus.dbg_valid  = dv;
    bus.dbg_reg    = REG_W'(dr);
    bus.dbg_data   = dd;
  endtask

  task automatic idle();
    set_in(0, 0, 0, '0, 0, 0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("reset rf_reg_write", 64'(bus.rf_reg_write), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset init_done", 64'(bus.init_done), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("init_done after release", 64'(bus.init_done), 64'(!CLR_EN));

    // Lone writeback request.
    set_in(0, 1, 1, 32'hA5A5A5A5, 0, 0, '0);
    @(negedge clk);
    chk("lone wb_ready", 64'(bus.wb_ready), 64'd1);
    chk("lone dbg_ready", 64'(bus.dbg_ready), 64'd0);
    tick();
    chk("lone rf_reg_write", 64'(bus.rf_reg_write), 64'd1);
    chk("lone rf_write_reg", 64'(bus.rf_write_reg), 64'd1);
    chk("lone rf_write_data", 64'(bus.rf_write_data), 64'hA5A5A5A5);

    // Both valid for six cycles: debug forced through on cycle 4.
    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, i + 2, 32'h1000 + i, 1, 20, 32'hD000 + i);
      @(negedge clk);
      chk("starve wb_ready", 64'(bus.wb_ready), 64'(i != 4));
      chk("starve dbg_ready", 64'(bus.dbg_ready), 64'(i == 4));
      tick();
      chk("starve rf_write_reg", 64'(bus.rf_write_reg), (i == 4) ? 64'd20 : 64'(i + 2));
    end

    // Debug write to register 0 is accepted but suppressed.
    set_in(0, 0, 0, '0, 1, 0, 32'hA5A5A5A6);
    @(negedge clk);
    chk("reg0 dbg_ready", 64'(bus.dbg_ready), 64'd1);
    tick();
    chk("reg0 rf_reg_write", 64'(bus.rf_reg_write), 64'd0);

    // No requests: no grant.
    idle();
    @(negedge clk);
    chk("idle wb_ready", 64'(bus.wb_ready), 64'd0);
    chk("idle dbg_ready", 64'(bus.dbg_ready), 64'd0);
    tick();

    // Mixed directed vectors.
    for (int i = 0; i < 24; i++) begin
      set_in(0, (i % 3) != 0, (i * 7) % NUM_REGS, 32'h01010101 * i ^ 32'h5A00_0000,
             (i % 4) < 2, (i * 5 + 3) % NUM_REGS, 32'hC0DE_0000 + i);
      tick();
    end

    // Start with requests pending: start wins when the clear is built in.
    set_in(1, 1, 3, 32'h33, 1, 4, 32'h44);
    @(negedge clk);
    chk("start blocks wb_ready", 64'(bus.wb_ready), 64'(!CLR_EN));
    tick();
    chk("init busy entry", 64'(bus.busy), 64'(CLR_EN));
    chk("init first reg", 64'(bus.rf_write_reg), CLR_EN ? 64'd1 : 64'd3);
    for (int k = 2; k < NUM_REGS; k++) begin
      set_in(k == 5, k < 12, 6, 32'h66, k < 12, 7, 32'h77);
      tick();
    end
    idle();
    if (CLR_EN) chk("init last reg", 64'(bus.rf_write_reg), 64'd31);
    chk("init busy last", 64'(bus.busy), 64'(CLR_EN));
    tick();
    chk("init done", 64'(bus.init_done), 64'd1);
    chk("init busy cleared", 64'(bus.busy), 64'd0);
    chk("init write ended", 64'(bus.rf_reg_write), 64'd0);

    // Reset in the middle of a clear sequence.
    set_in(1, 0, 0, '0, 0, 0, '0);
    tick();
    idle();
    for (int k = 2; k <= 10; k++) tick();
    if (CLR_EN) chk("pre-reset reg", 64'(bus.rf_write_reg), 64'd10);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset rf_reg_write", 64'(bus.rf_reg_write), 64'd0);
    chk("async reset rf_write_reg", 64'(bus.rf_write_reg), 64'd0);
    chk("async reset busy", 64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("post-reset init_done", 64'(bus.init_done), 64'(!CLR_EN));
    chk("post-reset no write", 64'(bus.rf_reg_write), 64'd0);

    // Debug drops out mid-contention, restarting its loss count.
    for (int i = 0; i < 10; i++) begin
      set_in(0, 1, 9, 32'h9000 + i, i != 3, 10, 32'hA000 + i);
      tick();
    end
    idle();
    tick(); tick();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
